// File: rtl/sync_dp_ram_clr.sv
// rtl/sync_dp_ram_clr.sv - dual-port video buffer RAM with lane masks, read pipeline and clear engine
module sync_dp_ram_clr #(
  parameter int ADDRESS_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int LANE_WIDTH = 8,
  parameter int READ_LATENCY = 1,
  parameter bit RDW_NEW = 1'b0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clear_req,
  output logic                               busy,
  input  logic                               wr_en,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0]   wr_mask,
  input  logic [ADDRESS_WIDTH-1:0]           wr_addr,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  input  logic                               rd_en,
  input  logic [ADDRESS_WIDTH-1:0]           rd_addr,
  output logic [DATA_WIDTH-1:0]              rd_data,
  output logic                               rd_valid
);

  localparam int LANES = DATA_WIDTH / LANE_WIDTH;
  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] clr_addr;
  logic [DATA_WIDTH-1:0]    mem [DEPTH];

  logic                     running;
  logic [DATA_WIDTH-1:0]    bit_mask;
  logic [DATA_WIDTH-1:0]    merged_word;
  logic [DATA_WIDTH-1:0]    read_word;
  logic                     s1_valid;
  logic [DATA_WIDTH-1:0]    s1_data;

  assign running = (state == RUN);

  always_comb begin
    bit_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      bit_mask[i*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{wr_mask[i]}};
    end
  end

  // Merged word only matters when a same-address write forwards into the read
  assign merged_word = (mem[wr_addr] & ~bit_mask) | (wr_data & bit_mask);
  assign read_word   = (RDW_NEW && wr_en && (wr_addr == rd_addr)) ? merged_word : mem[rd_addr];

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (!running) begin
        mem[clr_addr] <= CLEAR_VALUE;
      end else if (wr_en) begin
        for (int i = 0; i < LANES; i++) begin
          if (wr_mask[i]) begin
            mem[wr_addr][i*LANE_WIDTH +: LANE_WIDTH] <= wr_data[i*LANE_WIDTH +: LANE_WIDTH];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= CLEAR;
      clr_addr <= '0;
      busy     <= 1'b1;
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      case (state)
        CLEAR: begin
          s1_valid <= 1'b0;
          clr_addr <= clr_addr + 1'b1;
          if (&clr_addr) begin
            state <= RUN;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          if (clear_req) begin
            state    <= CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
            s1_valid <= 1'b0;
          end else begin
            s1_valid <= rd_en;
            if (rd_en) s1_data <= read_word;
          end
        end
        default: begin
          state <= CLEAR;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  s2_valid;
      logic [DATA_WIDTH-1:0] s2_data;

      // A clear request drops the read already sitting in the output stage too
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
        end else if (running && clear_req) begin
          s2_valid <= 1'b0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) s2_data <= s1_data;
        end
      end

      assign rd_valid = s2_valid;
      assign rd_data  = s2_data;
    end else begin : g_lat1
      assign rd_valid = s1_valid;
      assign rd_data  = s1_data;
    end
  endgenerate

endmodule

// File: tb/tb_sync_dp_ram_clr.sv
// tb/tb_sync_dp_ram_clr.sv - self-checking bench for sync_dp_ram_clr across three builds
module tb_sync_dp_ram_clr;

  localparam int DEPTH = 16;
  localparam logic [15:0] CV = 16'h0020;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear_req = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_mask = '0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_addr = '0;

  logic [2:0]        busy;
  logic [2:0]        rd_valid;
  logic [2:0][15:0]  rd_data;

  int checks = 0;
  int errors = 0;

  // Instance 0: latency 1 old-data, 1: latency 1 new-data, 2: latency 2 old-data
  sync_dp_ram_clr #(.ADDRESS_WIDTH(4), .DATA_WIDTH(16), .LANE_WIDTH(8), .READ_LATENCY(1),
                    .RDW_NEW(1'b0), .CLEAR_VALUE(CV)) u0 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy[0]), .wr_en(wr_en),
    .wr_mask(wr_mask), .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]));

  sync_dp_ram_clr #(.ADDRESS_WIDTH(4), .DATA_WIDTH(16), .LANE_WIDTH(8), .READ_LATENCY(1),
                    .RDW_NEW(1'b1), .CLEAR_VALUE(CV)) u1 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy[1]), .wr_en(wr_en),
    .wr_mask(wr_mask), .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]));

  sync_dp_ram_clr #(.ADDRESS_WIDTH(4), .DATA_WIDTH(16), .LANE_WIDTH(8), .READ_LATENCY(2),
                    .RDW_NEW(1'b0), .CLEAR_VALUE(CV)) u2 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy[2]), .wr_en(wr_en),
    .wr_mask(wr_mask), .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data[2]), .rd_valid(rd_valid[2]));

  always #5 clk = ~clk;

  // Reference model: word array, clear progress, and a list of pending read results
  typedef struct {
    int          inst;
    int          due;
    logic [15:0] data;
  } rd_t;

  logic [15:0] mem_m [DEPTH];
  bit          m_clear = 1'b1;
  int          m_cnt = 0;
  int          cyc = 0;
  rd_t         pend[$];
  bit          exp_busy = 1'b1;
  bit          exp_valid [3];
  logic [15:0] exp_data [3];

  task automatic step();
    logic [15:0] oldw;
    logic [15:0] neww;
    rd_t keep[$];
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_clear = 1'b1;
      m_cnt = 0;
      pend.delete();
      for (int i = 0; i < 3; i++) exp_data[i] = '0;
    end else if (m_clear) begin
      mem_m[m_cnt] = CV;
      m_cnt++;
      if (m_cnt == DEPTH) m_clear = 1'b0;
    end else begin
      oldw = mem_m[rd_addr];
      if (wr_en) begin
        for (int l = 0; l < 2; l++) begin
          if (wr_mask[l]) mem_m[wr_addr][l*8 +: 8] = wr_data[l*8 +: 8];
        end
      end
      neww = mem_m[rd_addr];
      if (clear_req) begin
        m_clear = 1'b1;
        m_cnt = 0;
        pend.delete();
      end else if (rd_en) begin
        pend.push_back('{inst: 0, due: cyc,     data: oldw});
        pend.push_back('{inst: 1, due: cyc,     data: neww});
        pend.push_back('{inst: 2, due: cyc + 1, data: oldw});
      end
    end
    exp_busy = m_clear;
    for (int i = 0; i < 3; i++) exp_valid[i] = 1'b0;
    foreach (pend[k]) begin
      if (pend[k].due == cyc) begin
        exp_valid[pend[k].inst] = 1'b1;
        exp_data[pend[k].inst] = pend[k].data;
      end
    end
    foreach (pend[k]) if (pend[k].due > cyc) keep.push_back(pend[k]);
    pend = keep;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy[i] !== 1'b1 || rd_valid[i] !== 1'b0 || rd_data[i] !== 16'h0) begin
        errors++;
        $display("FAIL reset_state inst=%0d busy=%b valid=%b data=%h required 1/0/0000",
                 i, busy[i], rd_valid[i], rd_data[i]);
      end
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (busy[i] !== 1'(k < 16)) begin
          errors++;
          $display("FAIL reset_busy inst=%0d cycle=%0d busy=%b required %b", i, k, busy[i], k < 16);
        end
      end
    end
    for (int a = 0; a < DEPTH; a++) begin
      rd_en = 1'b1;
      rd_addr = 4'(a);
      step();
      rd_en = 1'b0;
      checks++;
      if (rd_valid[0] !== 1'b1 || rd_data[0] !== CV) begin
        errors++;
        $display("FAIL reset_read addr=%0d valid=%b data=%h required 1/%h", a, rd_valid[0], rd_data[0], CV);
      end
      step();
      checks++;
      if (rd_valid[0] !== 1'b0 || rd_valid[2] !== 1'b1 || rd_data[2] !== CV) begin
        errors++;
        $display("FAIL reset_read_lat addr=%0d v0=%b v2=%b d2=%h required 0/1/%h",
                 a, rd_valid[0], rd_valid[2], rd_data[2], CV);
      end
    end
  endtask

  task automatic test_masked_write();
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hABCD; wr_mask = 2'b11;
    step();
    wr_data = 16'h1234; wr_mask = 2'b01;
    step();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 4'd5;
    step();
    rd_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd_valid[i] !== 1'b1 || rd_data[i] !== 16'hAB34) begin
        errors++;
        $display("FAIL masked_write inst=%0d valid=%b data=%h required 1/ab34", i, rd_valid[i], rd_data[i]);
      end
    end
    step();
    checks++;
    if (rd_valid[2] !== 1'b1 || rd_data[2] !== 16'hAB34) begin
      errors++;
      $display("FAIL masked_write_lat2 valid=%b data=%h required 1/ab34", rd_valid[2], rd_data[2]);
    end
  endtask

  task automatic test_rdw();
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h1111; wr_mask = 2'b11;
    step();
    wr_data = 16'h2222; rd_en = 1'b1; rd_addr = 4'd7;
    step();
    wr_en = 1'b0;
    checks++;
    if (rd_data[0] !== 16'h1111 || rd_data[1] !== 16'h2222 || rd_valid[1:0] !== 2'b11) begin
      errors++;
      $display("FAIL rdw_same_cycle old=%h new=%h valid=%b required 1111/2222/11",
               rd_data[0], rd_data[1], rd_valid[1:0]);
    end
    step();
    rd_en = 1'b0;
    checks++;
    if (rd_data[0] !== 16'h2222 || rd_data[1] !== 16'h2222 || rd_data[2] !== 16'h1111) begin
      errors++;
      $display("FAIL rdw_next_cycle d0=%h d1=%h d2=%h required 2222/2222/1111", rd_data[0], rd_data[1], rd_data[2]);
    end
    step();
    checks++;
    if (rd_valid[2] !== 1'b1 || rd_data[2] !== 16'h2222) begin
      errors++;
      $display("FAIL rdw_lat2_next valid=%b data=%h required 1/2222", rd_valid[2], rd_data[2]);
    end
  endtask

  task automatic test_latency2_stream();
    logic [15:0] want;
    bit          want_v;
    wr_en = 1'b1; wr_mask = 2'b11;
    for (int a = 0; a < 4; a++) begin
      wr_addr = 4'(a);
      wr_data = 16'h00A0 + 16'(a);
      step();
    end
    wr_en = 1'b0;
    for (int s = 1; s <= 7; s++) begin
      rd_en = (s <= 4);
      rd_addr = 4'(s - 1);
      step();
      want_v = (s >= 2 && s <= 5);
      want = 16'h00A0 + 16'((s >= 2 && s <= 5) ? s - 2 : 3);
      checks++;
      if (rd_valid[2] !== want_v || (s >= 2 && rd_data[2] !== want)) begin
        errors++;
        $display("FAIL lat2_stream step=%0d valid=%b data=%h required %b/%h", s, rd_valid[2], rd_data[2], want_v, want);
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_clear_mid_stream();
    rd_en = 1'b1; rd_addr = 4'd1;
    step();
    checks++;
    if (rd_valid[0] !== 1'b1 || rd_data[0] !== 16'h00A1) begin
      errors++;
      $display("FAIL clear_first_read valid=%b data=%h required 1/00a1", rd_valid[0], rd_data[0]);
    end
    rd_addr = 4'd2; clear_req = 1'b1;
    step();
    rd_en = 1'b0; clear_req = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      if (k > 1) begin
        clear_req = (k == 4);
        step();
        clear_req = 1'b0;
      end
      checks++;
      if (busy[0] !== 1'(k <= 16) || rd_valid !== 3'b000 || rd_data[0] !== 16'h00A1) begin
        errors++;
        $display("FAIL clear_busy k=%0d busy=%b valid=%b data=%h required %b/000/00a1",
                 k, busy[0], rd_valid, rd_data[0], k <= 16);
      end
    end
    for (int a = 0; a < DEPTH; a++) begin
      rd_en = 1'b1; rd_addr = 4'(a);
      step();
      checks++;
      if (rd_valid[1] !== 1'b1 || rd_data[1] !== CV) begin
        errors++;
        $display("FAIL clear_contents addr=%0d valid=%b data=%h required 1/%h", a, rd_valid[1], rd_data[1], CV);
      end
    end
    rd_en = 1'b0;
    step();
  endtask

  task automatic test_ignored_during_clear();
    int guard = 0;
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hFFFF; wr_mask = 2'b11;
    rd_en = 1'b1; rd_addr = 4'd3;
    while (busy[0] === 1'b1 && guard < 40) begin
      step();
      guard++;
      checks++;
      if (rd_valid !== 3'b000) begin
        errors++;
        $display("FAIL clear_ignore_valid cycle=%0d valid=%b required 000", guard, rd_valid);
      end
    end
    wr_en = 1'b0; rd_en = 1'b0;
    checks++;
    if (guard != 16) begin
      errors++;
      $display("FAIL clear_ignore_length cycles=%0d required 16", guard);
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    checks++;
    if (rd_valid[0] !== 1'b1 || rd_data[0] !== CV) begin
      errors++;
      $display("FAIL clear_ignore_addr3 valid=%b data=%h required 1/%h", rd_valid[0], rd_data[0], CV);
    end
    step();
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      rst_n = ($urandom_range(0, 249) != 0);
      clear_req = ($urandom_range(0, 59) == 0);
      wr_en = 1'($urandom_range(0, 1));
      wr_mask = 2'($urandom_range(0, 3));
      wr_addr = 4'($urandom_range(0, 15));
      wr_data = 16'($urandom);
      rd_en = 1'($urandom_range(0, 1));
      rd_addr = ($urandom_range(0, 2) == 0) ? wr_addr : 4'($urandom_range(0, 15));
      step();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (busy[i] !== exp_busy || rd_valid[i] !== exp_valid[i] || rd_data[i] !== exp_data[i]) begin
          errors++;
          $display("FAIL random cyc=%0d inst=%0d busy=%b valid=%b data=%h required %b/%b/%h",
                   cyc, i, busy[i], rd_valid[i], rd_data[i], exp_busy, exp_valid[i], exp_data[i]);
        end
      end
    end
    rst_n = 1'b1; clear_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      exp_valid[i] = 1'b0;
      exp_data[i] = '0;
    end
    test_reset();
    test_masked_write();
    test_rdw();
    test_latency2_stream();
    test_clear_mid_stream();
    test_ignored_during_clear();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_dp_ram_clr.md
Name: sync_dp_ram_clr

Overview:
Parametrised synchronous dual-port RAM (one write port, one read port) for VGA/C64 video buffers. Successor to the plain dual-port RAM, adding:
- per-lane write masks
- configurable read latency
- selectable read-during-write behaviour
- read-valid tracking
- a hardware clear engine that fills memory with CLEAR_VALUE after reset or on request
Screen and colour buffers can then be blanked without CPU writes.

Parameters:
ADDRESS_WIDTH, 12, address bits; depth = 2**ADDRESS_WIDTH words
DATA_WIDTH, 8, bits per word; must be a multiple of LANE_WIDTH
LANE_WIDTH, 8, bits per write-mask lane; LANES = DATA_WIDTH/LANE_WIDTH
READ_LATENCY, 1, cycles from rd_en sample to rd_valid; legal values 1 or 2
RDW_NEW, 0, same-address read+write in one cycle: 0 returns old data, 1 returns merged new data
CLEAR_VALUE, 0, DATA_WIDTH-bit word written to every address by the clear engine

Ports:
clk  in  1  single clock; all logic on posedge
rst_n  in  1  synchronous, active-low reset
clear_req  in  1  one-cycle pulse; starts a full clear when idle
busy  out  1  high while the clear engine owns the array
wr_en  in  1  write strobe
wr_mask  in  LANES  lane enables; bit i gates bits [i*LANE_WIDTH +: LANE_WIDTH]
wr_addr  in  ADDRESS_WIDTH  write address
wr_data  in  DATA_WIDTH  write data
rd_en  in  1  read strobe
rd_addr  in  ADDRESS_WIDTH  read address
rd_data  out  DATA_WIDTH  read data; holds last value when rd_valid is low
rd_valid  out  1  rd_data carries the result of a read

Behaviour:
Reset (rst_n=0 at a posedge):
- state=CLEAR, clear counter=0, busy=1, rd_valid=0, rd_data=0, read pipeline flushed.
- Array contents are not touched during reset itself.

States:
- CLEAR:
  - Each cycle writes CLEAR_VALUE to address counter (all lanes), then increments the counter.
  - The first clear write occurs on the first posedge with rst_n=1.
  - After address 2**ADDRESS_WIDTH-1 is written, next state is RUN.
  - busy is 1 throughout CLEAR, including the cycle of the last write; busy=0 on the following cycle.
  - A full clear takes exactly 2**ADDRESS_WIDTH cycles.
  - wr_en, rd_en and clear_req are ignored; rd_valid stays 0.
- RUN:
  - wr_en=1: for each lane i with wr_mask[i]=1, the lane is written at the posedge; unmasked lanes keep their value. wr_mask=0 with wr_en=1 is a no-op.
  - rd_en=1: the address is registered. Data and rd_valid=1 appear READ_LATENCY posedges later.
    - READ_LATENCY=2 adds one output register stage.
    - Back-to-back reads give one result per cycle.
  - clear_req=1: next state is CLEAR, counter=0, busy=1 on the next cycle.
    - Any write in the same cycle still completes.
    - In-flight reads are dropped: rd_valid=0 from the next cycle; rd_data holds.
- clear_req in CLEAR is ignored; there is no restart and no queuing.
- Reset mid-clear restarts the clear from address 0.

Read-during-write (RUN, rd_en and wr_en both 1, rd_addr==wr_addr):
- RDW_NEW=0: returns the word as stored before the write.
- RDW_NEW=1: returns the merged word (masked lanes from wr_data, other lanes old).
- A read issued the cycle after a write to the same address returns the written data regardless of RDW_NEW.

Addresses wrap naturally at the ADDRESS_WIDTH boundary; no out-of-range condition exists.

Test Plan:
(Parameters for all tests: ADDRESS_WIDTH=4, DATA_WIDTH=16, LANE_WIDTH=8, CLEAR_VALUE=16'h0020 unless stated.)
1. Reset release:
   - Stimulus: hold rst_n=0 for 3 cycles, release.
   - Required: busy=1 for exactly 16 cycles after release, then 0. Reads of all 16 addresses return 16'h0020 with rd_valid exactly 1 cycle after rd_en (READ_LATENCY=1).
2. Masked write:
   - Stimulus: write addr 5, data 16'hABCD, mask 2'b11; then addr 5, data 16'h1234, mask 2'b01; then read addr 5.
   - Required: rd_data=16'hAB34.
3. Read-during-write:
   - Stimulus: addr 7 holds 16'h1111; same cycle write 16'h2222 (mask 2'b11) and read addr 7.
   - Required: RDW_NEW=0 gives 16'h1111; RDW_NEW=1 gives 16'h2222. A read next cycle gives 16'h2222 in both builds.
4. READ_LATENCY=2 streaming:
   - Stimulus: rd_en on 4 consecutive cycles, addrs 0..3 preloaded with 16'h00A0..16'h00A3.
   - Required: rd_valid high for exactly 4 cycles starting 2 cycles after the first rd_en, data in order 16'h00A0..16'h00A3.
5. clear_req mid-stream:
   - Stimulus: in RUN, issue reads on cycles N and N+1 and clear_req on cycle N+1.
   - Required: rd_valid for the cycle-N read only; busy=1 from N+2 for 16 cycles. A second clear_req at N+5 has no effect. All words read 16'h0020 afterwards.
6. Ignored port activity during clear:
   - Stimulus: wr_en to addr 3 with 16'hFFFF, and rd_en, while busy=1.
   - Required: no rd_valid; addr 3 reads 16'h0020 after the clear completes.
